// File: rtl/conway_pkg.sv
// Shared types and default widths for the Game of Life sequencer.
// Holds the controller state encoding and the default parameter widths.
package conway_pkg;

    localparam int DEF_N_CELLS  = 64;
    localparam int DEF_PERIOD_W = 24;
    localparam int DEF_GEN_W    = 16;

    typedef enum logic [1:0] {
        S_LOAD,
        S_PAUSE,
        S_RUN,
        S_HALT
    } conway_state_t;

endpackage

// File: rtl/tick_divider.sv
// Generation-rate prescaler: pulses tick once every max(period,1) enabled cycles.
// Ports: clk, rst (async, active-low), clr (sync clear), en, period -> tick.
module tick_divider
    import conway_pkg::*;
#(
    parameter int PERIOD_W = DEF_PERIOD_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] count;
    logic [PERIOD_W-1:0] last;

    // period 0 behaves as 1; ">=" lets a shortened period wrap on the next compare
    assign last = (period == '0) ? '0 : period - PERIOD_W'(1);
    assign tick = en && (count >= last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr || tick) begin
            count <= '0;
        end else if (en) begin
            count <= count + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/conway_controller.sv
// Sequencer for the cell array: load, free-run or single-step, count and halt.
// Ports: clk, rst (async, active-low), run, step, load, period, board_q, board_d
//        -> cells_load, cells_ena, generation, stable, halted (all registered).
module conway_controller
    import conway_pkg::*;
#(
    parameter int N_CELLS   = DEF_N_CELLS,
    parameter int PERIOD_W  = DEF_PERIOD_W,
    parameter int GEN_W     = DEF_GEN_W,
    parameter int AUTO_HALT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                step,
    input  logic                load,
    input  logic [PERIOD_W-1:0] period,
    input  logic [N_CELLS-1:0]  board_q,
    input  logic [N_CELLS-1:0]  board_d,
    output logic                cells_load,
    output logic                cells_ena,
    output logic [GEN_W-1:0]    generation,
    output logic                stable,
    output logic                halted
);

    conway_state_t state;

    logic same;
    logic stop;
    logic div_en;
    logic div_clr;
    logic tick;

    assign same = (board_d == board_q);

    // the advance happening this cycle leaves the board unchanged
    assign stop = cells_ena && same && (AUTO_HALT != 0);

    // prescaler only runs while free-running; anything else parks it at 0
    assign div_en  = (state == S_RUN) && run;
    assign div_clr = load || !div_en;

    tick_divider #(
        .PERIOD_W (PERIOD_W)
    ) u_div (
        .clk    (clk),
        .rst    (rst),
        .clr    (div_clr),
        .en     (div_en),
        .period (period),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_LOAD;
            cells_load <= 1'b1;
            cells_ena  <= 1'b0;
            generation <= '0;
            stable     <= 1'b0;
            halted     <= 1'b0;
        end else begin
            cells_load <= 1'b0;
            cells_ena  <= 1'b0;

            if (cells_ena) begin
                if (generation != '1) begin
                    generation <= generation + GEN_W'(1);
                end
                stable <= same;
            end

            if (load) begin
                state      <= S_LOAD;
                cells_load <= 1'b1;
                generation <= '0;
                stable     <= 1'b0;
                halted     <= 1'b0;
            end else if (stop) begin
                state  <= S_HALT;
                halted <= 1'b1;
            end else begin
                unique case (state)
                    S_LOAD: begin
                        state <= run ? S_RUN : S_PAUSE;
                    end
                    S_PAUSE: begin
                        if (run) begin
                            state <= S_RUN;
                        end else begin
                            cells_ena <= step;
                        end
                    end
                    S_RUN: begin
                        if (!run) begin
                            state <= S_PAUSE;
                        end else begin
                            cells_ena <= tick;
                        end
                    end
                    S_HALT: begin
                        halted <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conway_controller.sv
// Randomized scoreboard bench for conway_controller.
// Two instances (GEN_W 16 and 3) share stimulus; a reference model predicts pulses.
module tb_conway_controller;

    localparam int NC = 64;
    localparam int PW = 24;
    localparam int AUTO_HALT = 1;

    logic          clk;
    logic          rst;
    logic          run;
    logic          step;
    logic          load;
    logic [PW-1:0] period;
    logic [NC-1:0] bq;
    logic [NC-1:0] bd;

    logic          cells_load;
    logic          cells_ena;
    logic [15:0]   generation;
    logic          stable;
    logic          halted;

    logic          cells_load3;
    logic          cells_ena3;
    logic [2:0]    generation3;
    logic          stable3;
    logic          halted3;

    conway_controller #(
        .N_CELLS (NC), .PERIOD_W (PW), .GEN_W (16), .AUTO_HALT (AUTO_HALT)
    ) dut (
        .clk (clk), .rst (rst), .run (run), .step (step), .load (load),
        .period (period), .board_q (bq), .board_d (bd),
        .cells_load (cells_load), .cells_ena (cells_ena),
        .generation (generation), .stable (stable), .halted (halted)
    );

    conway_controller #(
        .N_CELLS (NC), .PERIOD_W (PW), .GEN_W (3), .AUTO_HALT (AUTO_HALT)
    ) dut3 (
        .clk (clk), .rst (rst), .run (run), .step (step), .load (load),
        .period (period), .board_q (bq), .board_d (bd),
        .cells_load (cells_load3), .cells_ena (cells_ena3),
        .generation (generation3), .stable (stable3), .halted (halted3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_LOAD, M_PAUSE, M_RUN, M_HALT} mode_t;
    typedef struct {
        int cyc;
        int gen;
        bit stb;
    } pulse_t;

    mode_t  mode = M_LOAD;
    int     gen = 0;
    bit     stb = 1'b0;
    bit     ena_m = 1'b0;
    int     elapsed = 0;
    int     cyc = 0;
    pulse_t q[$];

    // elapsed = run cycles since entering RUN or since the last pulse
    always @(posedge clk) begin
        bit same;
        bit nxt;
        int eff;
        cyc++;
        if (!rst) begin
            mode = M_LOAD; gen = 0; stb = 1'b0; elapsed = 0; ena_m = 1'b0;
            q.delete();
        end else begin
            same = (bd == bq);
            nxt = 1'b0;
            eff = (period == '0) ? 1 : int'(period);
            if (ena_m) begin
                gen++;
                stb = same;
            end
            if (load) begin
                mode = M_LOAD; gen = 0; stb = 1'b0; elapsed = 0;
            end else if (ena_m && same && AUTO_HALT != 0) begin
                mode = M_HALT;
            end else begin
                case (mode)
                    M_LOAD: begin
                        mode = run ? M_RUN : M_PAUSE;
                        elapsed = 0;
                    end
                    M_PAUSE: begin
                        elapsed = 0;
                        if (run) mode = M_RUN;
                        else nxt = step;
                    end
                    M_RUN: begin
                        if (!run) begin
                            mode = M_PAUSE;
                            elapsed = 0;
                        end else begin
                            elapsed++;
                            if (elapsed >= eff) begin
                                nxt = 1'b1;
                                elapsed = 0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            ena_m = nxt;
            if (nxt) q.push_back('{cyc, gen, stb});
        end
    end

    // ---------------- monitor ----------------
    bit     exp_ena;
    pulse_t pe;
    int     g16;
    int     g3;

    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
        end else begin
            exp_ena = (q.size() != 0) && (q[0].cyc == cyc);
            g16 = (gen > 65535) ? 65535 : gen;
            g3  = (gen > 7) ? 7 : gen;
            chk("ena", int'(cells_ena), int'(exp_ena));
            chk("ena3", int'(cells_ena3), int'(exp_ena));
            chk("load", int'(cells_load), int'(mode == M_LOAD));
            chk("load3", int'(cells_load3), int'(mode == M_LOAD));
            chk("halted", int'(halted), int'(mode == M_HALT));
            chk("halted3", int'(halted3), int'(mode == M_HALT));
            chk("gen", int'(generation), g16);
            chk("gen3", int'(generation3), g3);
            chk("stable", int'(stable), int'(stb));
            chk("stable3", int'(stable3), int'(stb));
            if (exp_ena) begin
                pe = q.pop_front();
                chk("pulse_gen", int'(generation), pe.gen);
                chk("pulse_stable", int'(stable), int'(pe.stb));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic logic [NC-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_load"}, int'(cells_load), 1);
        chk({tag, "_ena"}, int'(cells_ena), 0);
        chk({tag, "_gen"}, int'(generation), 0);
        chk({tag, "_gen3"}, int'(generation3), 0);
        chk({tag, "_stable"}, int'(stable), 0);
        chk({tag, "_halted"}, int'(halted), 0);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; step = 1'b0; load = 1'b0;
        period = PW'(5);
        bq = rnd64();
        bd = ~bq;
        #1 rst = 1'b0;
        cycle(3);
        chk_reset_vals("rst");

        // release: one LOAD cycle, then PAUSE
        rst = 1'b1;
        #1 chk("load_at_release", int'(cells_load), 1);
        cycle(1);
        chk("load_one_cycle", int'(cells_load), 0);

        // three single steps
        repeat (3) begin
            step = 1'b1; cycle(1);
            step = 1'b0; cycle(2);
        end
        chk("steps_gen", int'(generation), 3);

        // reload and free-run at period 5
        load = 1'b1; run = 1'b1; cycle(1);
        load = 1'b0; cycle(23);
        chk("p5_gen", int'(generation), 4);
        chk("p5_stable", int'(stable), 0);

        // period 0: advance every cycle, 3-bit counter saturates
        period = '0;
        cycle(10);
        chk("p0_gen", int'(generation), 13);
        chk("p0_gen3_sat", int'(generation3), 7);

        // blinker then block: second advance is still
        load = 1'b1; run = 1'b0; period = PW'(5); cycle(1);
        load = 1'b0; cycle(1);
        step = 1'b1; cycle(1);
        step = 1'b0; cycle(2);
        bd = bq;
        step = 1'b1; cycle(1);
        step = 1'b0; cycle(2);
        chk("block_stable", int'(stable), 1);
        chk("block_halted", int'(halted), 1);
        run = 1'b1;
        repeat (5) begin
            step = 1'b1; cycle(1);
            step = 1'b0; cycle(1);
        end
        chk("halt_hold_gen", int'(generation), 2);
        chk("halt_hold", int'(halted), 1);

        // load and step together out of HALT
        run = 1'b0; load = 1'b1; step = 1'b1; cycle(1);
        load = 1'b0; step = 1'b0;
        chk("reload_load", int'(cells_load), 1);
        chk("reload_ena", int'(cells_ena), 0);
        chk("reload_gen", int'(generation), 0);
        chk("reload_stable", int'(stable), 0);
        chk("reload_halted", int'(halted), 0);
        cycle(1);
        chk("reload_done", int'(cells_load), 0);
        cycle(3);

        // randomized traffic
        repeat (400) begin
            run  = ($urandom_range(0, 9) < 6);
            step = ($urandom_range(0, 3) == 0);
            load = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 7) == 0) period = PW'($urandom_range(0, 6));
            bq = rnd64();
            bd = ($urandom_range(0, 3) == 0) ? bq : (bq ^ (rnd64() | 64'd1));
            cycle(1);
        end

        // async reset in the middle of RUN
        step = 1'b0; load = 1'b1; run = 1'b1; period = PW'(3);
        bd = ~bq;
        cycle(1);
        load = 1'b0;
        cycle(8);
        rst = 1'b0;
        #1 chk_reset_vals("async");
        cycle(2);
        rst = 1'b1;
        cycle(12);
        run = 1'b0;
        cycle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
